// File: rtl/fir_pkg.sv
// Shared FIR delay-line definitions: default sizes and the reader/MAC state encoding.
package fir_pkg;

  localparam int DW_DEF    = 8;
  localparam int NTAPS_DEF = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/fir_mod_counter.sv
// Modulo-N up/down counter with parallel load; cnt_dn exposes the wrapped predecessor.
module fir_mod_counter #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_dn
);

  localparam logic [W-1:0] MAX = W'(N - 1);

  logic [W-1:0] cnt_up;

  assign cnt_up = (cnt == MAX) ? '0 : cnt + 1'b1;
  assign cnt_dn = (cnt == '0) ? MAX : cnt - 1'b1;

  // load wins over inc, inc over dec
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (inc)  cnt <= cnt_up;
    else if (dec)  cnt <= cnt_dn;
  end

endmodule

// File: rtl/fir_tap_reader.sv
// FIR delay-line reader: store one sample, then stream NTAPS taps newest-to-oldest.
// Optional FIR_TAP_READER_WARMUP_SKIP_EN suppresses bursts until the line is primed.
module fir_tap_reader
  import fir_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int NTAPS = NTAPS_DEF,
  localparam int IDXW  = $clog2(NTAPS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  output logic            t_valid,
  input  logic            t_ready,
  output logic [DW-1:0]   t_data,
  output logic [IDXW-1:0] t_idx,
  output logic            t_last,
  output logic            primed
);

  localparam int CW = $clog2(NTAPS + 1);

  state_t                  state, state_nxt;
  logic [NTAPS-1:0][DW-1:0] mem;
  logic [IDXW-1:0]         wr_ptr, rd_ptr, rd_dn, wr_dn_unused;
  logic [CW-1:0]           acc_cnt;
  logic                    accept, xfer, primed_nxt, burst_go;

  assign s_ready    = (state == IDLE) && !rst;
  assign accept     = s_valid && s_ready;
  assign xfer       = t_valid && t_ready;
  assign primed     = (acc_cnt == CW'(NTAPS));
  assign primed_nxt = primed || (acc_cnt == CW'(NTAPS - 1));

`ifdef FIR_TAP_READER_WARMUP_SKIP_EN
  assign burst_go = accept && primed_nxt;
`else
  assign burst_go = accept;
`endif

  fir_mod_counter #(.N(NTAPS), .W(IDXW)) u_wr_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (accept),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .cnt      (wr_ptr),
    .cnt_dn   (wr_dn_unused)
  );

  // rd_ptr starts at the slot being written; the first beat bypasses mem
  fir_mod_counter #(.N(NTAPS), .W(IDXW)) u_rd_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (1'b0),
    .dec      (xfer),
    .load     (accept),
    .load_val (wr_ptr),
    .cnt      (rd_ptr),
    .cnt_dn   (rd_dn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mem     <= '0;
      acc_cnt <= '0;
    end else if (accept) begin
      mem[wr_ptr] <= s_data;
      if (!primed) acc_cnt <= acc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (burst_go)      state_nxt = BURST;
      BURST:   if (xfer && t_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_valid <= 1'b0;
      t_data  <= '0;
      t_idx   <= '0;
      t_last  <= 1'b0;
    end else if (burst_go) begin
      t_valid <= 1'b1;
      t_data  <= s_data;
      t_idx   <= '0;
      t_last  <= 1'b0;
    end else if (xfer) begin
      if (t_last) begin
        t_valid <= 1'b0;
        t_idx   <= '0;
        t_last  <= 1'b0;
      end else begin
        t_data  <= mem[rd_dn];
        t_idx   <= t_idx + 1'b1;
        t_last  <= (t_idx == IDXW'(NTAPS - 2));
      end
    end
  end

endmodule
